// File: rtl/stage1_sched_pkg.sv
// Shared stage-1 definitions: scheduler state encoding and default hazard gap.
package stage1_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    localparam int GAP_DEFAULT = 2;

endpackage

// File: rtl/stage1_sched_rr_arb2.sv
// Two-requester round-robin arbiter; requester A wins ties after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_b_q, prio_b_d;

    always_comb begin
        gnt_a_o  = 1'b0;
        gnt_b_o  = 1'b0;
        prio_b_d = prio_b_q;
        if (en_i) begin
            if (req_a_i && (!req_b_i || !prio_b_q)) begin
                gnt_a_o = 1'b1;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
            end
        end
        // The requester just served drops to lowest priority.
        if (gnt_a_o) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_o) begin
            prio_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/stage1_sched.sv
// Stage-1 request scheduler: arbitrates insert/search issue into the sketch hash
// datapath, enforces the insert RMW gap, and sweeps both sketch RAMs to zero on clear.
module stage1_sched
    import stage1_sched_pkg::*;
#(
    parameter int HW  = 10,
    parameter int DW  = 64,
    parameter int GAP = GAP_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_valid_i,
    input  logic [DW-1:0] ins_data_i,
    output logic          ins_ready_o,
    input  logic          srch_valid_i,
    input  logic [DW-1:0] srch_data_i,
    output logic          srch_ready_o,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          clr_done_o,
    output logic          s1_insert_o,
    output logic [DW-1:0] s1_insert_data_o,
    output logic          s1_search_o,
    output logic [DW-1:0] s1_search_data_o,
    input  logic [DW-1:0] s1_search_freq_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_freq_o,
    output logic          clr_we_o,
    output logic [HW-1:0] clr_addr_o,
    output state_e        state_o
);

    localparam int          CW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [HW-1:0] ADDR_MAX = {HW{1'b1}};

    state_e          state_q, state_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            clr_pend_q, clr_pend_d;
    logic [HW-1:0]   clr_addr_q, clr_addr_d;
    logic            clr_done_q, clr_done_d;
    logic            ins_q, ins_d;
    logic [DW-1:0]   ins_data_q, ins_data_d;
    logic            srch_q, srch_d;
    logic [DW-1:0]   srch_data_q, srch_data_d;
    logic            srch_pipe_q, srch_pipe_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_freq_q, resp_freq_d;

    logic arb_en;
    logic gnt_ins, gnt_srch;

    // Handshake: a request transfers in a cycle where its valid and ready are both
    // high; ready is only raised for the single granted requester, in IDLE, with no clear.
    assign arb_en = (state_q == S_IDLE) && !clr_i && !clr_pend_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arb_en),
        .req_a_i (ins_valid_i),
        .req_b_i (srch_valid_i),
        .gnt_a_o (gnt_ins),
        .gnt_b_o (gnt_srch)
    );

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        clr_pend_d   = clr_pend_q;
        clr_addr_d   = clr_addr_q;
        clr_done_d   = 1'b0;
        ins_d        = gnt_ins;
        ins_data_d   = gnt_ins ? ins_data_i : ins_data_q;
        srch_d       = gnt_srch;
        srch_data_d  = gnt_srch ? srch_data_i : srch_data_q;
        // Search responses drain regardless of state, so they always return in order.
        srch_pipe_d  = srch_q;
        resp_valid_d = srch_pipe_q;
        resp_freq_d  = srch_pipe_q ? s1_search_freq_i : resp_freq_q;

        case (state_q)
            S_IDLE: begin
                if (clr_i || clr_pend_q) begin
                    state_d    = S_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_addr_d = '0;
                end else if (gnt_ins && (GAP > 0)) begin
                    state_d   = S_GAP;
                    gap_cnt_d = CW'(GAP - 1);
                end
            end
            S_GAP: begin
                if (clr_i) begin
                    clr_pend_d = 1'b1;
                end
                if (gap_cnt_q == '0) begin
                    if (clr_pend_q || clr_i) begin
                        state_d    = S_CLEAR;
                        clr_pend_d = 1'b0;
                        clr_addr_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_CLEAR: begin
                if (clr_addr_q == ADDR_MAX) begin
                    state_d    = S_IDLE;
                    clr_addr_d = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            clr_pend_q   <= 1'b0;
            clr_addr_q   <= '0;
            clr_done_q   <= 1'b0;
            ins_q        <= 1'b0;
            ins_data_q   <= '0;
            srch_q       <= 1'b0;
            srch_data_q  <= '0;
            srch_pipe_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_freq_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            clr_pend_q   <= clr_pend_d;
            clr_addr_q   <= clr_addr_d;
            clr_done_q   <= clr_done_d;
            ins_q        <= ins_d;
            ins_data_q   <= ins_data_d;
            srch_q       <= srch_d;
            srch_data_q  <= srch_data_d;
            srch_pipe_q  <= srch_pipe_d;
            resp_valid_q <= resp_valid_d;
            resp_freq_q  <= resp_freq_d;
        end
    end

    assign ins_ready_o      = gnt_ins;
    assign srch_ready_o     = gnt_srch;
    assign busy_o           = (state_q == S_GAP) || (state_q == S_CLEAR);
    assign clr_done_o       = clr_done_q;
    assign s1_insert_o      = ins_q;
    assign s1_insert_data_o = ins_data_q;
    assign s1_search_o      = srch_q;
    assign s1_search_data_o = srch_data_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_freq_o      = resp_freq_q;
    assign clr_we_o         = (state_q == S_CLEAR);
    assign clr_addr_o       = clr_addr_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_stage1_sched.sv
// Directed bench for stage1_sched: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_stage1_sched;
    import stage1_sched_pkg::*;

    localparam int HW = 4;
    localparam int DW = 64;
    localparam int W  = 3 + 32 + DW;

    localparam logic [2:0] K_INS  = 3'd0;
    localparam logic [2:0] K_SRCH = 3'd1;
    localparam logic [2:0] K_RESP = 3'd2;
    localparam logic [2:0] K_CLR  = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;

    logic          clk;
    logic          rst;
    logic          ins_valid_i;
    logic [DW-1:0] ins_data_i;
    logic          ins_ready_o;
    logic          srch_valid_i;
    logic [DW-1:0] srch_data_i;
    logic          srch_ready_o;
    logic          clr_i;
    logic          busy_o;
    logic          clr_done_o;
    logic          s1_insert_o;
    logic [DW-1:0] s1_insert_data_o;
    logic          s1_search_o;
    logic [DW-1:0] s1_search_data_o;
    logic [DW-1:0] s1_search_freq_i;
    logic          resp_valid_o;
    logic [DW-1:0] resp_freq_o;
    logic          clr_we_o;
    logic [HW-1:0] clr_addr_o;
    state_e        state_o;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    stage1_sched #(.HW(HW), .DW(DW), .GAP(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .ins_valid_i      (ins_valid_i),
        .ins_data_i       (ins_data_i),
        .ins_ready_o      (ins_ready_o),
        .srch_valid_i     (srch_valid_i),
        .srch_data_i      (srch_data_i),
        .srch_ready_o     (srch_ready_o),
        .clr_i            (clr_i),
        .busy_o           (busy_o),
        .clr_done_o       (clr_done_o),
        .s1_insert_o      (s1_insert_o),
        .s1_insert_data_o (s1_insert_data_o),
        .s1_search_o      (s1_search_o),
        .s1_search_data_o (s1_search_data_o),
        .s1_search_freq_i (s1_search_freq_i),
        .resp_valid_o     (resp_valid_o),
        .resp_freq_o      (resp_freq_o),
        .clr_we_o         (clr_we_o),
        .clr_addr_o       (clr_addr_o),
        .state_o          (state_o)
    );

    // ---------------- clock / cycle stamp ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hash datapath stub: frequency for key k is k + 6, presented the cycle after issue.
    always @(posedge clk) s1_search_freq_i <= s1_search_o ? (s1_search_data_o + 64'd6) : '0;

    // ---------------- scoreboard helpers ----------------
    task automatic push(input logic [2:0] kind, input int stamp, input logic [DW-1:0] data);
        exp_q.push_back({kind, 32'(stamp), data});
    endtask

    task automatic push_clear(input int start, input int n, input bit with_done);
        for (int k = 0; k < n; k++) push(K_CLR, start + k, 64'(k));
        if (with_done) push(K_DONE, start + n, '0);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input logic [2:0] kind, input logic [DW-1:0] data, input string name);
        int idx;
        logic [W-1:0] e;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i][W-1 -: 3] == kind) idx = i;
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL %s: unexpected event data 0x%0h at cycle %0d, none required", name, data, cyc);
        end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
            if (e[DW +: 32] != 32'(cyc) || e[DW-1:0] !== data) begin
                bad++;
                $display("FAIL %s: got data 0x%0h at cycle %0d, want data 0x%0h at cycle %0d",
                         name, data, cyc, e[DW-1:0], e[DW +: 32]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (s1_insert_o)  check_ev(K_INS,  s1_insert_data_o, "s1_insert");
        if (s1_search_o)  check_ev(K_SRCH, s1_search_data_o, "s1_search");
        if (resp_valid_o) check_ev(K_RESP, resp_freq_o,      "resp");
        if (clr_we_o)     check_ev(K_CLR,  64'(clr_addr_o),  "clr_we");
        if (clr_done_o)   check_ev(K_DONE, '0,               "clr_done");
    end

    // ---------------- driver ----------------
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic sv,
                        input logic [DW-1:0] sd, input logic clr,
                        input logic e_ir, input logic e_sr, input logic e_busy);
        @(negedge clk);
        ins_valid_i  = iv;
        ins_data_i   = id;
        srch_valid_i = sv;
        srch_data_i  = sd;
        clr_i        = clr;
        #1;
        chk("ins_ready",  64'(ins_ready_o),  64'(e_ir));
        chk("srch_ready", 64'(srch_ready_o), 64'(e_sr));
        chk("busy",       64'(busy_o),       64'(e_busy));
        if (iv && e_ir) push(K_INS, cyc + 1, id);
        if (sv && e_sr) begin
            push(K_SRCH, cyc + 1, sd);
            push(K_RESP, cyc + 3, sd + 64'd6);
        end
    endtask

    task automatic idle(input int n, input logic e_busy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, e_busy);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s1_insert"},  64'(s1_insert_o),    '0);
        chk({tag, "_ins_data"},   s1_insert_data_o,    '0);
        chk({tag, "_s1_search"},  64'(s1_search_o),    '0);
        chk({tag, "_srch_data"},  s1_search_data_o,    '0);
        chk({tag, "_resp_valid"}, 64'(resp_valid_o),   '0);
        chk({tag, "_resp_freq"},  resp_freq_o,         '0);
        chk({tag, "_clr_we"},     64'(clr_we_o),       '0);
        chk({tag, "_clr_addr"},   64'(clr_addr_o),     '0);
        chk({tag, "_clr_done"},   64'(clr_done_o),     '0);
        chk({tag, "_busy"},       64'(busy_o),         '0);
        chk({tag, "_ins_ready"},  64'(ins_ready_o),    '0);
        chk({tag, "_srch_ready"}, 64'(srch_ready_o),   '0);
        chk({tag, "_state"},      64'(state_o),        64'(S_IDLE));
    endtask

    initial begin
        int c;
        rst          = 1'b0;
        ins_valid_i  = 1'b0;
        ins_data_i   = '0;
        srch_valid_i = 1'b0;
        srch_data_i  = '0;
        clr_i        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single insert: 2 stalled cycles, next insert 3 cycles after the first
        step(1'b1, 64'h5, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h6, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h6, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h6, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(1, 1'b0);

        // Four back-to-back searches, responses 7..10
        for (int k = 1; k <= 4; k++) step(1'b0, '0, 1'b1, 64'(k), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);

        // Both valid continuously: insert, gap, gap, search, insert, gap, gap, search
        step(1'b1, 64'h10, 1'b1, 64'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h11, 1'b1, 64'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h11, 1'b1, 64'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h11, 1'b1, 64'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h11, 1'b1, 64'h21, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h12, 1'b1, 64'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h12, 1'b1, 64'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h12, 1'b1, 64'h21, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Clear from IDLE with a search in flight; requests stalled, re-clear ignored
        step(1'b0, '0, 1'b1, 64'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h40, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        push_clear(cyc + 1, 16, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 64'h40, 1'b1, 64'hA, (i == 5), 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("state_after_clear", 64'(state_o), 64'(S_IDLE));
        idle(2, 1'b0);

        // Clear requested during GAP: CLEAR follows GAP expiry directly
        step(1'b1, 64'h30, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        push_clear(cyc + 2, 16, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("state_clear_after_gap", 64'(state_o), 64'(S_CLEAR));
        idle(15, 1'b1);
        idle(3, 1'b0);

        // Reset while sweeping address 5: no done pulse, everything back to zero
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        c = cyc;
        push_clear(c + 1, 6, 1'b0);
        idle(5, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midclr_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(20, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage1_sched.md
STAGE1_SCHED -- requirements
Module: stage1_sched

Interface
REQ-001 SHALL have parameter HW, default 10, hash/address width of the sketch RAMs.
REQ-002 SHALL have parameter DW, default 64, key and counter width.
REQ-003 SHALL have parameter GAP, default 2, idle cycles enforced after each insert issue (read-modify-write hazard window).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ins_valid_i  in  1  insert request valid.
REQ-007 SHALL have port ins_data_i  in  DW  insert key.
REQ-008 SHALL have port ins_ready_o  out  1  insert accepted this cycle when high with ins_valid_i.
REQ-009 SHALL have port srch_valid_i  in  1  search request valid.
REQ-010 SHALL have port srch_data_i  in  DW  search key.
REQ-011 SHALL have port srch_ready_o  out  1  search accepted this cycle when high with srch_valid_i.
REQ-012 SHALL have port clr_i  in  1  single-cycle pulse, zero both sketch RAMs.
REQ-013 SHALL have port busy_o  out  1  high in GAP or CLEAR state.
REQ-014 SHALL have port clr_done_o  out  1  one-cycle pulse when clear sweep completes.
REQ-015 SHALL have ports s1_insert_o / s1_insert_data_o  out  1 / DW  registered insert issue to the stage-1 hash datapath.
REQ-016 SHALL have ports s1_search_o / s1_search_data_o  out  1 / DW  registered search issue to the stage-1 hash datapath.
REQ-017 SHALL have port s1_search_freq_i  in  DW  count-min value from the stage-1 hash datapath.
REQ-018 SHALL have ports resp_valid_o / resp_freq_o  out  1 / DW  search response.
REQ-019 SHALL have ports clr_we_o / clr_addr_o  out  1 / HW  zero-write override for RAM A and RAM B write ports.

Function
REQ-020 SHALL implement FSM states IDLE, GAP, CLEAR.
REQ-021 SHALL accept at most one request per cycle, and only in IDLE.
REQ-022 SHALL arbitrate round-robin when ins_valid_i and srch_valid_i are both high; after reset, insert has priority.
REQ-023 SHALL assert exactly one of s1_insert_o or s1_search_o in the cycle after acceptance, with the key registered.
REQ-024 SHALL go IDLE->GAP on insert acceptance and hold GAP for GAP cycles (down-counter), then return to IDLE; ins_ready_o and srch_ready_o are low throughout.
REQ-025 SHALL allow back-to-back search acceptance every cycle in IDLE.
REQ-026 SHALL capture s1_search_freq_i one cycle after s1_search_o and drive resp_valid_o high for one cycle the following cycle (acceptance-to-response latency 3 cycles).
REQ-027 SHALL track in-flight searches with a 2-stage valid shift register so responses return in issue order.
REQ-028 SHALL enter CLEAR on clr_i in IDLE, or on expiry of GAP if clr_i arrived during GAP; the pending clear is latched.
REQ-029 SHALL, in CLEAR, assert clr_we_o with clr_addr_o counting 0..2^HW-1, one address per cycle, then pulse clr_done_o and return to IDLE.
REQ-030 SHALL block new requests in CLEAR while still completing in-flight search responses.
REQ-031 SHALL ignore clr_i during CLEAR (no restart).
REQ-032 SHALL wrap clr_addr_o from 2^HW-1 to 0 only at sweep end, without overflow into other logic.

Reset
REQ-033 SHALL reset to IDLE with all outputs 0, and clear the counters, the pending-clear latch and the round-robin pointer (insert priority).
REQ-034 SHALL abandon a clear sweep on reset mid-operation; no clr_done_o pulse is issued.

Structure
REQ-035 SHALL place the FSM state encoding and the default GAP in the shared stage-1 package.
REQ-036 SHALL keep the round-robin arbiter as sub-module rr_arb2; everything else stays flat.

Verification
REQ-037 Single insert key 0x5 -> s1_insert_o high 1 cycle later; ins_ready_o low for 2 cycles; next insert accepted 3 cycles after the first.
REQ-038 4 back-to-back searches with freq stub returning 7, 8, 9, 10 -> 4 resp_valid_o pulses, in order, each 3 cycles after its acceptance.
REQ-039 Both valid continuously -> issue pattern insert, search, insert, search, with GAP stalls after each insert.
REQ-040 clr_i with HW=4 -> clr_we_o for 16 cycles, addr 0..15, then clr_done_o pulse; requests stalled throughout.
REQ-041 clr_i during GAP -> CLEAR entered the cycle GAP expires.
REQ-042 rst low at clear addr 5 -> all outputs 0, state IDLE, no clr_done_o pulse.
